// File: rtl/mc_core_multi.sv
// mc_core_multi: Monte-Carlo path pricer core.
// Walks N_PATHS x S path-ROM addresses, looks up exp(sigma*W) and exp(mu*t)
// in double-banked tables, multiplies in Q3.15 and accumulates the Q4.14
// products into a wide non-wrapping sum.
//
// state | meaning
// IDLE  | waiting for iStart; tables freely writable
// RUN   | issuing one path-ROM address per cycle
// DRAIN | addresses done, products still in the pipeline
// DONE  | oPrice valid, waiting for iReady
module mc_core_multi #(
    parameter CORE_ID = "1",
    parameter int LOG_T  = 9,
    parameter int LOG_P  = 2,
    parameter int PATH_W = 10,
    parameter int DATA_W = 18
) (
    input  logic                            CLK,
    input  logic                            iRST,
    input  logic                            iStart,
    input  logic [LOG_T-1:0]                iSteps,
    input  logic                            iSwitch,
    output logic [LOG_P+LOG_T-1:0]          oPathAddr,
    input  logic [PATH_W-1:0]               iPathData,
    input  logic                            iSigmaWE,
    input  logic [PATH_W-1:0]               iSigmaWriteAddress,
    input  logic [DATA_W-1:0]               iSigmaWriteData,
    input  logic                            iMuWE,
    input  logic [LOG_T-1:0]                iMuWriteAddress,
    input  logic [DATA_W-1:0]               iMuWriteData,
    output logic [DATA_W+LOG_T+LOG_P-1:0]   oPrice,
    output logic                            oValid,
    input  logic                            iReady,
    output logic                            oBusy,
    output logic                            oOverflow
);

    localparam int ACC_W = DATA_W + LOG_T + LOG_P;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]          state;
    logic [LOG_P-1:0]    p_cnt;
    logic [LOG_T-1:0]    t_cnt;
    logic [LOG_T-1:0]    t_last;
    logic                bank;
    logic                start_ok;
    logic                active;

    logic                v1, v2, v3, v4, v5;
    logic [LOG_T-1:0]    t1;
    logic [DATA_W-1:0]   sigma_rd, mu_rd;
    logic [2*DATA_W-1:0] full;
    logic [DATA_W+1:0]   prod_top;
    logic [DATA_W+1:0]   prod_q;
    logic [DATA_W-1:0]   prod4, prod5;
    logic                ovf4, ovf5;
    logic [ACC_W-1:0]    acc;
    logic                ovf_flag;
    logic                sigma_we_ok, mu_we_ok;

    logic [DATA_W-1:0] sigma_mem [0:2*(2**PATH_W)-1];
    logic [DATA_W-1:0] mu_mem    [0:2*(2**LOG_T)-1];

    assign start_ok  = (state == IDLE) && iStart;
    assign active    = (state != IDLE);
    assign oPathAddr = {p_cnt, t_cnt};
    assign oBusy     = (state == RUN) || (state == DRAIN);
    assign oValid    = (state == DONE);
    assign oPrice    = acc;
    assign oOverflow = ovf_flag;

    // While a run owns bank B, a write that would land there (iSwitch flipped
    // mid-run) is dropped so the run sees a frozen table.
    assign sigma_we_ok = iSigmaWE && !(active && ((~iSwitch) == bank));
    assign mu_we_ok    = iMuWE    && !(active && ((~iSwitch) == bank));

    // Full product is kept only for its upper 20 bits: Q4.14 value plus the two
    // saturation-detect bits.
    assign full     = {{DATA_W{1'b0}}, sigma_rd} * {{DATA_W{1'b0}}, mu_rd};
    assign prod_top = (DATA_W+2)'(full >> 16);

    // Table write ports and one-cycle synchronous reads; contents survive reset.
    always_ff @(posedge CLK) begin
        if (sigma_we_ok)
            sigma_mem[{~iSwitch, iSigmaWriteAddress}] <= iSigmaWriteData;
        if (mu_we_ok)
            mu_mem[{~iSwitch, iMuWriteAddress}] <= iMuWriteData;
        sigma_rd <= sigma_mem[{bank, iPathData}];
        mu_rd    <= mu_mem[{bank, t1}];
    end

    // Sequencer: run latch, {p,t} address walk and state transitions.
    always_ff @(posedge CLK) begin
        if (iRST) begin
            state  <= IDLE;
            p_cnt  <= '0;
            t_cnt  <= '0;
            t_last <= '0;
            bank   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state  <= RUN;
                        t_last <= iSteps;
                        bank   <= iSwitch;
                        p_cnt  <= '0;
                        t_cnt  <= '0;
                    end
                end
                RUN: begin
                    if (t_cnt == t_last) begin
                        t_cnt <= '0;
                        if (p_cnt == {LOG_P{1'b1}}) begin
                            p_cnt <= '0;
                            state <= DRAIN;
                        end else begin
                            p_cnt <= p_cnt + 1'b1;
                        end
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // last product is in the accumulate stage and nothing follows it
                    if (v5 && !v4)
                        state <= DONE;
                end
                default: begin
                    if (iReady)
                        state <= IDLE;
                end
            endcase
        end
    end

    // Product pipeline: ROM data, table read, multiply, saturate, accumulate stage.
    always_ff @(posedge CLK) begin
        if (iRST) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            v4     <= 1'b0;
            v5     <= 1'b0;
            t1     <= '0;
            prod_q <= '0;
            prod4  <= '0;
            prod5  <= '0;
            ovf4   <= 1'b0;
            ovf5   <= 1'b0;
        end else begin
            v1     <= (state == RUN);
            t1     <= t_cnt;
            v2     <= v1;
            v3     <= v2;
            prod_q <= prod_top;
            v4     <= v3;
            ovf4   <= |prod_q[DATA_W+1:DATA_W];
            prod4  <= (|prod_q[DATA_W+1:DATA_W]) ? {DATA_W{1'b1}} : prod_q[DATA_W-1:0];
            v5     <= v4;
            prod5  <= prod4;
            ovf5   <= ovf4;
        end
    end

    // Accumulator and sticky overflow, cleared at run start.
    always_ff @(posedge CLK) begin
        if (iRST) begin
            acc      <= '0;
            ovf_flag <= 1'b0;
        end else if (start_ok) begin
            acc      <= '0;
            ovf_flag <= 1'b0;
        end else if (v5) begin
            acc      <= acc + ACC_W'(prod5);
            ovf_flag <= ovf_flag | ovf5;
        end
    end

endmodule

// File: tb/tb_mc_core_multi.sv
// Directed bench for mc_core_multi with a registered path-ROM model (LOG_P=1).
module tb_mc_core_multi;

    localparam int LOG_T  = 9;
    localparam int LOG_P  = 1;
    localparam int PATH_W = 10;
    localparam int DATA_W = 18;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          start = 1'b0;
    logic [LOG_T-1:0]              steps = '0;
    logic                          sw = 1'b0;
    logic [LOG_P+LOG_T-1:0]        path_addr;
    logic [PATH_W-1:0]             path_data = '0;
    logic                          sigma_we = 1'b0;
    logic [PATH_W-1:0]             sigma_wa = '0;
    logic [DATA_W-1:0]             sigma_wd = '0;
    logic                          mu_we = 1'b0;
    logic [LOG_T-1:0]              mu_wa = '0;
    logic [DATA_W-1:0]             mu_wd = '0;
    logic [DATA_W+LOG_T+LOG_P-1:0] price;
    logic                          valid;
    logic                          ready = 1'b0;
    logic                          busy;
    logic                          ovf;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    mc_core_multi #(.CORE_ID("1"), .LOG_T(LOG_T), .LOG_P(LOG_P), .PATH_W(PATH_W), .DATA_W(DATA_W)) dut (
        .CLK(clk), .iRST(rst), .iStart(start), .iSteps(steps), .iSwitch(sw),
        .oPathAddr(path_addr), .iPathData(path_data),
        .iSigmaWE(sigma_we), .iSigmaWriteAddress(sigma_wa), .iSigmaWriteData(sigma_wd),
        .iMuWE(mu_we), .iMuWriteAddress(mu_wa), .iMuWriteData(mu_wd),
        .oPrice(price), .oValid(valid), .iReady(ready), .oBusy(busy), .oOverflow(ovf)
    );

    always #5 clk = ~clk;

    // path ROM: data valid one cycle after the address
    always @(posedge clk) path_data <= path_addr ^ 10'h2A5;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // fill the whole sigma and mu tables of target bank tb (writes go to ~iSwitch)
    task automatic fill(input logic tb, input logic [DATA_W-1:0] d);
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            sw       = ~tb;
            sigma_we = 1'b1;
            sigma_wa = PATH_W'(i);
            sigma_wd = d;
            mu_we    = (i < 512);
            mu_wa    = LOG_T'(i);
            mu_wd    = d;
        end
        @(negedge clk);
        sigma_we = 1'b0;
        mu_we    = 1'b0;
    endtask

    // returns just after the start-sample edge, i.e. at the beginning of cycle 1
    task automatic start_run(input logic [LOG_T-1:0] s, input logic b);
        @(negedge clk);
        steps = s;
        sw    = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_valid(input int from, output int c);
        c = -1;
        for (int n = from; n < from + 300; n++) begin
            @(negedge clk);
            if (valid) begin
                c = n;
                break;
            end
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 64'(valid), 64'd0);
    endtask

    initial begin
        // reset with a simultaneous start request: reset must win
        start = 1'b1;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_ovf",   64'(ovf),   64'd0);
        check("rst_price", 64'(price), 64'd0);
        check("rst_addr",  64'(path_addr), 64'd0);

        fill(1'b0, 18'h08000);
        fill(1'b1, 18'h3FFFF);

        // address order, two steps: {0,0},{0,1},{1,0},{1,1} -> 0,1,512,513
        start_run(9'd1, 1'b0);
        @(negedge clk);
        check("ord_busy", 64'(busy), 64'd1);
        check("ord_a1", 64'(path_addr), 64'd0);
        @(negedge clk);
        check("ord_a2", 64'(path_addr), 64'd1);
        @(negedge clk);
        check("ord_a3", 64'(path_addr), 64'd512);
        @(negedge clk);
        check("ord_a4", 64'(path_addr), 64'd513);
        wait_valid(5, cyc);
        check("ord_vcyc", 64'(cyc), 64'd10);
        check("ord_price", 64'(price), 64'h10000);
        handshake("ord");

        // basic run: 8 products of 0x4000
        start_run(9'd3, 1'b0);
        wait_valid(1, cyc);
        check("basic_vcyc",  64'(cyc), 64'd14);
        check("basic_price", 64'(price), 64'h20000);
        check("basic_ovf",   64'(ovf), 64'd0);
        check("basic_busy",  64'(busy), 64'd0);
        handshake("basic");

        // saturation on bank 1
        start_run(9'd0, 1'b1);
        wait_valid(1, cyc);
        check("sat_vcyc",  64'(cyc), 64'd8);
        check("sat_price", 64'(price), 64'h7FFFE);
        check("sat_ovf",   64'(ovf), 64'd1);
        handshake("sat");

        // bank isolation: run bank 0 while zeroing bank 1
        start_run(9'd3, 1'b0);
        fill(1'b1, 18'h00000);
        wait_valid(1, cyc);
        check("iso_price", 64'(price), 64'h20000);
        check("iso_ovf",   64'(ovf), 64'd0);
        handshake("iso");
        start_run(9'd3, 1'b1);
        // attempt to overwrite bank 1 while it is in use; must be dropped
        fill(1'b1, 18'h3FFFF);
        wait_valid(1, cyc);
        check("iso1_price", 64'(price), 64'h0);
        handshake("iso1");
        start_run(9'd3, 1'b1);
        wait_valid(1, cyc);
        check("prot_price", 64'(price), 64'h0);
        check("prot_ovf",   64'(ovf), 64'd0);
        handshake("prot");

        // backpressure with start pulses that must be ignored
        start_run(9'd3, 1'b0);
        wait_valid(1, cyc);
        check("bp_vcyc", 64'(cyc), 64'd14);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check("bp_valid", 64'(valid), 64'd1);
            check("bp_price", 64'(price), 64'h20000);
            check("bp_busy",  64'(busy),  64'd0);
        end
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 begin
            ready = 1'b0;
            start = 1'b0;
        end
        @(negedge clk);
        check("bp_valid_drop", 64'(valid), 64'd0);
        check("bp_no_restart", 64'(busy),  64'd0);
        @(negedge clk);
        check("bp_still_idle", 64'(busy),  64'd0);

        // reset in cycle 5 of a basic run
        start_run(9'd3, 1'b0);
        repeat (5) @(negedge clk);
        check("mrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_busy",  64'(busy),  64'd0);
        check("mrst_valid", 64'(valid), 64'd0);
        check("mrst_price", 64'(price), 64'd0);
        check("mrst_addr",  64'(path_addr), 64'd0);
        repeat (8) @(negedge clk);
        check("mrst_quiet", 64'(valid), 64'd0);
        start_run(9'd3, 1'b0);
        wait_valid(1, cyc);
        check("mrst_vcyc",  64'(cyc), 64'd14);
        check("mrst_price2", 64'(price), 64'h20000);
        handshake("mrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_core_multi.md
MC_CORE_MULTI -- requirements
Module: mc_core_multi

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CORE_ID, "1", core identifier
- LOG_T, 9, log2 of max time steps; T_MAX = 2^LOG_T
- LOG_P, 2, log2 of paths per run; N_PATHS = 2^LOG_P
- PATH_W, 10, Brownian-index width and sigma-table address width
- DATA_W, 18, table and product width; fixed at 18
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, single clock, rising edge
- iRST, in, 1, reset; synchronous, active-high
- iStart, in, 1, start request, sampled in IDLE only
- iSteps, in, LOG_T, step count minus 1 (0 means 1 step), latched at start
- iSwitch, in, 1, read-bank select, latched at start
- oPathAddr, out, LOG_P+LOG_T, external path ROM address {p,t}
- iPathData, in, PATH_W, path ROM data, valid 1 cycle after oPathAddr
- iSigmaWE / iSigmaWriteAddress / iSigmaWriteData, in, 1/PATH_W/18, exp(sigma*W) table write
- iMuWE / iMuWriteAddress / iMuWriteData, in, 1/LOG_T/18, exp(mu*t) table write
- oPrice, out, 18+LOG_T+LOG_P, sum of products, unsigned, 14 fraction bits
- oValid, out, 1, oPrice valid
- iReady, in, 1, consumer accepts oPrice
- oBusy, out, 1, high in RUN or DRAIN
- oOverflow, out, 1, sticky product-saturation flag for the current result

Function
REQ-003 FSM states SHALL be IDLE, RUN, DRAIN and DONE: IDLE->RUN on iStart; RUN->DRAIN after the last address; DRAIN->DONE when the last product is accumulated; DONE->IDLE when oValid&&iReady.
REQ-004 On start, the block SHALL latch S=iSteps+1 and bank B=iSwitch, clear the accumulator and clear oOverflow.
REQ-005 In RUN, the block SHALL issue one address per cycle for N_PATHS*S cycles, with p outer (0..N_PATHS-1), t inner (0..S-1), and oPathAddr={p,t}.
REQ-006 Step (p,t) SHALL read sigma bank B at iPathData and mu bank B at t; mu SHALL be shared by all paths.
REQ-007 Tables SHALL be two-bank RAMs with one-cycle synchronous read; sigma depth 2^PATH_W, mu depth T_MAX.
REQ-008 Writes SHALL always target bank ~iSwitch (current value) and SHALL never alter bank B contents seen by a run in progress.
REQ-009 Multiply SHALL be unsigned Q3.15 x Q3.15 = 36-bit full product; product = bits[33:16] (Q4.14).
REQ-010 If full-product bits[35:34] are nonzero, the product SHALL saturate to 0x3FFFF and oOverflow SHALL be set.
REQ-011 The accumulator SHALL be 18+LOG_T+LOG_P bits wide and SHALL never wrap.
REQ-012 Latency: address issued in cycle k (start-sample cycle = 0, first address k=1) SHALL be accumulated at the end of cycle k+5; oValid SHALL rise in cycle N_PATHS*S+6.
REQ-013 oPrice and oOverflow SHALL be held stable while oValid=1 and iReady=0; oValid SHALL deassert the cycle after the oValid&&iReady handshake.
REQ-014 iStart SHALL be ignored outside IDLE, including the handshake cycle.
REQ-015 oBusy SHALL be 1 exactly in RUN and DRAIN.

Reset
REQ-016 When iRST=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-run; pipeline valids SHALL be cleared; oValid, oBusy and oOverflow SHALL be 0; oPrice and the accumulator SHALL be 0; oPathAddr SHALL be 0.
REQ-017 Reset SHALL NOT clear table contents.
REQ-018 iRST SHALL take priority over iStart in the same cycle.

Verification
REQ-019 Basic run, LOG_P=1, iSteps=3, all mu=sigma=0x08000 -> 8 products of 0x4000; oPrice=0x20000; oValid in cycle 14; oOverflow=0.
REQ-020 Saturation, iSteps=0, mu=sigma=0x3FFFF -> oPrice=0x7FFFE (2 paths); oOverflow=1.
REQ-021 Bank isolation: run on bank 0 while rewriting all of bank 1 with 0 -> result identical to REQ-019; then iSwitch=1 run -> oPrice=0.
REQ-022 Backpressure: iReady=0 for 10 cycles after oValid with iStart pulsed -> oPrice held, no new run; handshake -> oValid=0 next cycle.
REQ-023 Reset mid-run: iRST in cycle 5 of REQ-019 -> oBusy=0, oValid=0 next cycle; subsequent run -> 0x20000.
REQ-024 Address order, iSteps=1 -> oPathAddr sequence {0,0},{0,1},{1,0},{1,1} in cycles 1-4.
